heartbeat_pwm: RTL and testbench
================================

Name: heartbeat_pwm

Overview:
Downstream consumer of the selectable-rate divider's slow square-wave output. Each rising edge of that signal is one envelope step. The block runs a double-pulse "lub-dub" brightness envelope through a state machine and drives the LED pin with a glitch-free PWM carrier at clk/2^PWM_BITS. The divider's period selection therefore sets heartbeat tempo.

Parameters:
PWM_BITS, 8, duty/PWM counter width.
STEP, 8, duty increment/decrement per envelope tick; must be ≥1 and ≤ PEAK2.
PEAK1, 255, first-beat peak duty; must be ≤ 2^PWM_BITS-1.
PEAK2, 160, second-beat peak duty; must be ≥ STEP.
GAP_TICKS, 20, ticks between beat 1 and beat 2; must be ≥1.
REST_TICKS, 60, ticks after beat 2 before the next beat; must be ≥1.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
step_clk  in  1  divided clock from the divider, synchronous to clk; each rising edge is one tick.
enable  in  1  heartbeat run request.
led_out  out  1  registered PWM output.
duty  out  PWM_BITS  current envelope duty.
phase  out  3  FSM state encoding.
beat_pulse  out  1  one-clk pulse when beat-1 peak is reached.

Behaviour:
- Reset (async, rst_n=0) clears everything: led_out=0, duty=0, phase=IDLE(0), beat_pulse=0, pwm_cnt=0, duty shadow=0, gap/rest counter=0, step_clk delay reg=0. Takes effect immediately, including mid-sequence.
- Tick detect: step_d <= step_clk each clk. tick = step_clk & ~step_d, one clk wide. Every FSM/duty update occurs at the clk edge where tick=1; no other edge changes them.
- FSM encoding: IDLE=0, RISE1=1, FALL1=2, GAP=3, RISE2=4, FALL2=5, REST=6. phase = state.
- IDLE: duty=0. On a tick with enable=1, go to RISE1 with duty unchanged (0).
- RISE1, on each tick:
  - if duty+STEP ≥ PEAK1: duty<=PEAK1, go to FALL1, beat_pulse=1 for the following clk only.
  - else duty<=duty+STEP.
  - Sum computed at PWM_BITS+1 bits; no wrap.
- FALL1, on each tick: if duty ≤ STEP, duty<=0, go to GAP, cnt<=0. Else duty<=duty-STEP. No underflow.
- GAP, on each tick: cnt++. On the tick where cnt==GAP_TICKS-1, go to RISE2 with cnt<=0. Duty stays 0.
- RISE2/FALL2: same rules as RISE1/FALL1 using PEAK2. No beat_pulse. FALL2 exits to REST with cnt<=0.
- REST: duty 0. On the tick where cnt==REST_TICKS-1, go to RISE1 if enable=1, else IDLE.
- enable=0 outside IDLE: the current sequence completes through REST, then IDLE. Dropping enable never truncates a beat.
- Sequence length from RISE1 entry to RISE1 re-entry (defaults): 32+32+20+20+20+60 = 184 ticks.
- PWM carrier:
  - pwm_cnt is a free-running PWM_BITS counter, +1 every clk, wraps at all-ones→0.
  - Duty shadow loads duty when pwm_cnt==all-ones.
  - led_out <= (pwm_cnt < shadow), registered.
  - shadow=0 gives led_out constantly 0. shadow=255 gives 255 high of every 256 clks.
  - A tick coinciding with the wrap cycle: the shadow captures the pre-tick duty; the new duty applies from the next carrier period.
- A step_clk held constant (divider in its default/off state) produces no ticks. The FSM and duty freeze; the PWM carrier keeps running.

Test Plan:
1. Reset, then toggle step_clk 10× with enable=0 -> phase=0, duty=0, led_out=0 throughout, beat_pulse never set.
2. enable=1, one tick -> phase=1, duty=0. 31 more ticks -> duty=248. 1 more -> duty=255, phase=2, beat_pulse high exactly 1 clk.
3. Continue ticking -> FALL1 reaches duty=0/phase=3 after 32 ticks. GAP lasts 20 ticks. RISE2 peaks at 160 after 20 ticks. FALL2 takes 20 ticks. REST 60. Back at phase=1, duty=0, 184 ticks after the first RISE1 entry.
4. Freeze at duty=255 (stop ticks in FALL1 entry) -> over 512 clks, led_out high 510. Tick mid-period -> new duty=247 seen only after the next pwm_cnt wrap (247 high/256).
5. Drop enable during FALL1 -> sequence completes GAP/RISE2/FALL2/REST, then phase=0, duty=0, stays idle with further ticks.
6. Assert rst_n=0 mid-RISE1 (duty=120) -> led_out, duty, phase zero immediately without a clk edge. Release and tick with enable=1 -> clean restart from RISE1, duty 0.

Source files
------------

// File: rtl/heartbeat_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : heartbeat_pwm
//  Description : "Lub-dub" double-pulse brightness envelope stepped by the
//                rising edges of a slow divided clock, driving an LED through
//                a glitch-free PWM carrier at clk/2^PWM_BITS.
//  Revision    : 1.0 - initial release
// ============================================================================
module heartbeat_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 8,
  parameter int PEAK1      = 255,
  parameter int PEAK2      = 160,
  parameter int GAP_TICKS  = 20,
  parameter int REST_TICKS = 60
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_clk,
  input  logic                enable,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          phase,
  output logic                beat_pulse
);

  // Gap/rest counter only needs to reach the larger of the two tick counts.
  localparam int CNT_MAX = (GAP_TICKS > REST_TICKS) ? GAP_TICKS : REST_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RISE1 = 3'd1;
  localparam logic [2:0] FALL1 = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] RISE2 = 3'd4;
  localparam logic [2:0] FALL2 = 3'd5;
  localparam logic [2:0] REST  = 3'd6;

  // Rise comparisons are done one bit wider so duty+STEP can never wrap.
  localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS+1)'(STEP);
  localparam logic [PWM_BITS:0]   PEAK1_X   = (PWM_BITS+1)'(PEAK1);
  localparam logic [PWM_BITS:0]   PEAK2_X   = (PWM_BITS+1)'(PEAK2);
  localparam logic [PWM_BITS-1:0] STEP_D    = PWM_BITS'(STEP);
  localparam logic [PWM_BITS-1:0] PEAK1_D   = PWM_BITS'(PEAK1);
  localparam logic [PWM_BITS-1:0] PEAK2_D   = PWM_BITS'(PEAK2);
  localparam logic [PWM_BITS-1:0] PWM_TOP   = '1;
  localparam logic [CNT_W-1:0]    GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0]    REST_LAST = CNT_W'(REST_TICKS - 1);

  logic                step_d;
  logic                tick;
  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [PWM_BITS-1:0] duty_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                pulse_nxt;
  logic [PWM_BITS:0]   sum_ext;
  logic                peak1_hit;
  logic                peak2_hit;
  logic                floor_hit;
  logic                gap_done;
  logic                rest_done;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] shadow;

  // Delay step_clk one clk so its rising edge becomes a one-clk tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_d <= 1'b0;
    else        step_d <= step_clk;
  end

  assign tick      = step_clk & ~step_d;
  assign sum_ext   = {1'b0, duty} + STEP_X;
  assign peak1_hit = (sum_ext >= PEAK1_X);
  assign peak2_hit = (sum_ext >= PEAK2_X);
  assign floor_hit = (duty <= STEP_D);
  assign gap_done  = (cnt == GAP_LAST);
  assign rest_done = (cnt == REST_LAST);
  assign phase     = state;

  // Envelope state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the envelope only advances on a tick.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        IDLE:    if (enable)    state_nxt = RISE1;
        RISE1:   if (peak1_hit) state_nxt = FALL1;
        FALL1:   if (floor_hit) state_nxt = GAP;
        GAP:     if (gap_done)  state_nxt = RISE2;
        RISE2:   if (peak2_hit) state_nxt = FALL2;
        FALL2:   if (floor_hit) state_nxt = REST;
        // enable is only sampled here, so dropping it never cuts a beat short.
        REST:    if (rest_done) state_nxt = enable ? RISE1 : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-state duty, counter and beat-marker updates applied on a tick.
  always_comb begin
    duty_nxt  = duty;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    if (tick) begin
      case (state)
        IDLE: duty_nxt = '0;
        RISE1: begin
          if (peak1_hit) begin
            duty_nxt  = PEAK1_D;
            pulse_nxt = 1'b1;
          end else begin
            duty_nxt = sum_ext[PWM_BITS-1:0];
          end
        end
        RISE2: begin
          if (peak2_hit) duty_nxt = PEAK2_D;
          else           duty_nxt = sum_ext[PWM_BITS-1:0];
        end
        FALL1, FALL2: begin
          if (floor_hit) begin
            duty_nxt = '0;
            cnt_nxt  = '0;
          end else begin
            duty_nxt = duty - STEP_D;
          end
        end
        GAP: begin
          duty_nxt = '0;
          cnt_nxt  = gap_done ? '0 : cnt + 1'b1;
        end
        REST: begin
          duty_nxt = '0;
          cnt_nxt  = rest_done ? '0 : cnt + 1'b1;
        end
        default: begin
          duty_nxt = '0;
          cnt_nxt  = '0;
        end
      endcase
    end
  end

  // Envelope datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty       <= '0;
      cnt        <= '0;
      beat_pulse <= 1'b0;
    end else begin
      duty       <= duty_nxt;
      cnt        <= cnt_nxt;
      beat_pulse <= pulse_nxt;
    end
  end

  // PWM carrier: duty is latched only at the wrap so a period is never split.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      led_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == PWM_TOP) shadow <= duty;
      led_out <= (pwm_cnt < shadow);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_heartbeat_pwm
//  Description : Directed self-checking bench for heartbeat_pwm (defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_heartbeat_pwm;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       step_clk = 1'b0;
  logic       enable   = 1'b0;
  logic       led_out;
  logic [7:0] duty;
  logic [2:0] phase;
  logic       beat_pulse;

  int total = 0;
  int bad   = 0;

  // Reference carrier position: free-running from reset release.
  logic [7:0] ref_pwm;

  heartbeat_pwm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_clk   (step_clk),
    .enable     (enable),
    .led_out    (led_out),
    .duty       (duty),
    .phase      (phase),
    .beat_pulse (beat_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_pwm <= 8'd0;
    else        ref_pwm <= ref_pwm + 8'd1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Expected phase k ticks after a RISE1 entry (k=184 is the next re-entry).
  function automatic logic [2:0] exp_phase(input int k, input bit en);
    if (k < 32)  return 3'd1;
    if (k < 64)  return 3'd2;
    if (k < 84)  return 3'd3;
    if (k < 104) return 3'd4;
    if (k < 124) return 3'd5;
    if (k < 184) return 3'd6;
    return en ? 3'd1 : 3'd0;
  endfunction

  // Expected duty k ticks after a RISE1 entry.
  function automatic logic [7:0] exp_duty(input int k);
    if (k <= 31)  return 8'(8 * k);
    if (k == 32)  return 8'd255;
    if (k <= 63)  return 8'(255 - 8 * (k - 32));
    if (k <= 84)  return 8'd0;
    if (k <= 103) return 8'(8 * (k - 84));
    if (k == 104) return 8'd160;
    if (k <= 123) return 8'(160 - 8 * (k - 104));
    return 8'd0;
  endfunction

  // One step_clk rising edge; returns at the negedge after the tick edge.
  task automatic do_tick();
    @(negedge clk);
    step_clk = 1'b1;
    @(negedge clk);
    step_clk = 1'b0;
  endtask

  // Bounded wait for a carrier position, sampled at negedge.
  task automatic wait_ref(input logic [7:0] v);
    int guard;
    guard = 0;
    while (ref_pwm !== v && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (ref_pwm !== v) begin
      total++; bad++;
      $display("FAIL wait_ref: carrier position %0d not reached, at %0d", v, ref_pwm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; step_clk = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (led_out !== 1'b0)    begin bad++; $display("FAIL reset_led: got %b want 0", led_out); end
    total++; if (duty !== 8'd0)       begin bad++; $display("FAIL reset_duty: got %0d want 0", duty); end
    total++; if (phase !== 3'd0)      begin bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
    total++; if (beat_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", beat_pulse); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_no_enable();
    for (int i = 0; i < 10; i++) begin
      do_tick();
      total++;
      if (phase !== 3'd0 || duty !== 8'd0 || led_out !== 1'b0 || beat_pulse !== 1'b0) begin
        bad++;
        $display("FAIL idle_tick%0d: phase=%0d duty=%0d led=%b pulse=%b want all 0",
                 i, phase, duty, led_out, beat_pulse);
      end
    end
  endtask

  task automatic test_rise1();
    enable = 1'b1;
    do_tick();
    total++;
    if (phase !== 3'd1 || duty !== 8'd0) begin
      bad++; $display("FAIL rise1_entry: phase=%0d duty=%0d want 1/0", phase, duty);
    end
    for (int k = 1; k <= 31; k++) begin
      do_tick();
      total++;
      if (phase !== 3'd1 || duty !== 8'(8 * k) || beat_pulse !== 1'b0) begin
        bad++;
        $display("FAIL rise1_k%0d: phase=%0d duty=%0d pulse=%b want 1/%0d/0",
                 k, phase, duty, beat_pulse, 8 * k);
      end
    end
    do_tick();
    total++;
    if (phase !== 3'd2 || duty !== 8'd255) begin
      bad++; $display("FAIL rise1_peak: phase=%0d duty=%0d want 2/255", phase, duty);
    end
    total++;
    if (beat_pulse !== 1'b1) begin
      bad++; $display("FAIL beat_pulse_high: got %b want 1", beat_pulse);
    end
    @(negedge clk);
    total++;
    if (beat_pulse !== 1'b0) begin
      bad++; $display("FAIL beat_pulse_width: got %b want 0 one clk later", beat_pulse);
    end
  endtask

  task automatic test_pwm_freeze();
    int highs;
    repeat (300) @(negedge clk);
    highs = 0;
    repeat (512) begin
      @(negedge clk);
      if (led_out === 1'b1) highs++;
    end
    total++;
    if (highs != 510) begin
      bad++; $display("FAIL pwm_full_duty: high=%0d of 512 want 510", highs);
    end
    wait_ref(8'd128);
    do_tick();
    total++;
    if (phase !== 3'd2 || duty !== 8'd247) begin
      bad++; $display("FAIL fall1_first: phase=%0d duty=%0d want 2/247", phase, duty);
    end
    // Late in the same period the old shadow (255) must still be in effect.
    wait_ref(8'd251);
    total++;
    if (led_out !== 1'b1) begin
      bad++; $display("FAIL pwm_no_midperiod_update: led=%b want 1", led_out);
    end
    wait_ref(8'd0);
    highs = 0;
    repeat (256) begin
      @(negedge clk);
      if (led_out === 1'b1) highs++;
    end
    total++;
    if (highs != 247) begin
      bad++; $display("FAIL pwm_new_duty: high=%0d of 256 want 247", highs);
    end
  endtask

  task automatic test_full_sequence();
    for (int k = 34; k <= 184; k++) begin
      do_tick();
      total++;
      if (phase !== exp_phase(k, 1'b1) || duty !== exp_duty(k) || beat_pulse !== 1'b0) begin
        bad++;
        $display("FAIL seq_k%0d: phase=%0d duty=%0d pulse=%b want %0d/%0d/0",
                 k, phase, duty, beat_pulse, exp_phase(k, 1'b1), exp_duty(k));
      end
    end
  endtask

  task automatic test_enable_drop();
    for (int k = 1; k <= 184; k++) begin
      do_tick();
      if (k == 33) enable = 1'b0;
      total++;
      if (phase !== exp_phase(k, 1'b0) || duty !== exp_duty(k) || beat_pulse !== (k == 32)) begin
        bad++;
        $display("FAIL drop_k%0d: phase=%0d duty=%0d pulse=%b want %0d/%0d/%b",
                 k, phase, duty, beat_pulse, exp_phase(k, 1'b0), exp_duty(k), (k == 32));
      end
    end
    for (int i = 0; i < 5; i++) begin
      do_tick();
      total++;
      if (phase !== 3'd0 || duty !== 8'd0) begin
        bad++; $display("FAIL drop_idle%0d: phase=%0d duty=%0d want 0/0", i, phase, duty);
      end
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    do_tick();
    repeat (15) do_tick();
    total++;
    if (phase !== 3'd1 || duty !== 8'd120) begin
      bad++; $display("FAIL mid_setup: phase=%0d duty=%0d want 1/120", phase, duty);
    end
    @(negedge clk);
    wait_ref(8'd0);
    wait_ref(8'd10);
    total++;
    if (led_out !== 1'b1) begin
      bad++; $display("FAIL mid_led_on: led=%b want 1", led_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (led_out !== 1'b0 || duty !== 8'd0 || phase !== 3'd0 || beat_pulse !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: led=%b duty=%0d phase=%0d pulse=%b want all 0",
               led_out, duty, phase, beat_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_tick();
    total++;
    if (phase !== 3'd1 || duty !== 8'd0) begin
      bad++; $display("FAIL restart_entry: phase=%0d duty=%0d want 1/0", phase, duty);
    end
    do_tick();
    total++;
    if (phase !== 3'd1 || duty !== 8'd8) begin
      bad++; $display("FAIL restart_step: phase=%0d duty=%0d want 1/8", phase, duty);
    end
  endtask

  initial begin
    test_reset();
    test_idle_no_enable();
    test_rise1();
    test_pwm_freeze();
    test_full_sequence();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
